// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM state encoding,
// parity-mode constants and the default oversampling ratio.
package uart_pkg;

   // Default clk cycles per serial bit
   localparam int unsigned CLKS_PER_BIT_DEFAULT = 186;

   // Parity modes
   localparam int unsigned PARITY_NONE = 0;
   localparam int unsigned PARITY_ODD  = 1;
   localparam int unsigned PARITY_EVEN = 2;

   // Receiver FSM states
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } rx_state_e;

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for an asynchronous single-bit input.
// Ports:
//   clk, rst : clock and asynchronous active-high reset
//   d        : asynchronous input
//   q        : synchronized output (2-cycle latency)
module uart_sync #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   // Both flops reset to the idle level so reset release creates no edge
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= RESET_VAL;
         q    <= RESET_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx_core.sv
// UART receiver: synchronizes the serial line, detects the start edge,
// samples each bit at mid-bit, checks parity and stop bits, and holds the
// received word with its error flags until the consumer accepts it.
// Ports:
//   clk, rst    : clock and asynchronous active-high reset
//   uart_DI     : asynchronous serial input
//   uart_DO     : received word (first bit on the line is the LSB)
//   uart_valid  : uart_DO and flags hold a word
//   uart_ready  : consumer accepts the word when uart_valid && uart_ready
//   frame_err   : a stop bit of the held word was at the start level
//   parity_err  : parity mismatch on the held word
//   overrun     : a frame was dropped while the held word was unaccepted
//   busy        : receiver is inside a frame
module uart_rx_core
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
   parameter int unsigned DATA_BITS    = 8,
   parameter int unsigned PARITY       = PARITY_NONE,
   parameter int unsigned STOP_BITS    = 2,
   parameter logic        IDLE_LEVEL   = 1'b1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 uart_DI,
   output logic [DATA_BITS-1:0] uart_DO,
   output logic                 uart_valid,
   input  logic                 uart_ready,
   output logic                 frame_err,
   output logic                 parity_err,
   output logic                 overrun,
   output logic                 busy
);

   localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
   localparam int unsigned IDX_W = 4;

   localparam logic [CNT_W-1:0] CNT_MID       = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] CNT_LAST      = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] IDX_DATA_LAST = IDX_W'(DATA_BITS - 1);
   localparam logic [IDX_W-1:0] IDX_STOP_LAST = IDX_W'(STOP_BITS - 1);
   localparam logic             START_LEVEL   = !IDLE_LEVEL;

   rx_state_e              state, state_next;
   logic [CNT_W-1:0]       cnt, cnt_next;
   logic [IDX_W-1:0]       bit_idx, bit_idx_next;
   logic [DATA_BITS-1:0]   shreg, shreg_next;
   logic                   ferr_q, ferr_next;
   logic                   perr_q, perr_next;
   logic                   rx_s;
   logic                   rx_prev;
   logic                   par_xor;
   logic                   frame_done_c;

   // Line synchronizer
   uart_sync #(
      .RESET_VAL (IDLE_LEVEL)
   ) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (uart_DI),
      .q   (rx_s)
   );

   // XOR of the assembled data word with the sampled parity bit
   assign par_xor = (^shreg) ^ rx_s;

   // State and datapath registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= ST_IDLE;
         cnt     <= '0;
         bit_idx <= '0;
         shreg   <= '0;
         ferr_q  <= 1'b0;
         perr_q  <= 1'b0;
         rx_prev <= IDLE_LEVEL;
         busy    <= 1'b0;
      end else begin
         state   <= state_next;
         cnt     <= cnt_next;
         bit_idx <= bit_idx_next;
         shreg   <= shreg_next;
         ferr_q  <= ferr_next;
         perr_q  <= perr_next;
         rx_prev <= rx_s;
         busy    <= (state_next != ST_IDLE);
      end
   end

   // Next-state and per-frame datapath
   always_comb begin
      state_next   = state;
      cnt_next     = cnt;
      bit_idx_next = bit_idx;
      shreg_next   = shreg;
      ferr_next    = ferr_q;
      perr_next    = perr_q;
      frame_done_c = 1'b0;

      case (state)
         ST_IDLE: begin
            cnt_next     = '0;
            bit_idx_next = '0;
            if ((rx_prev == IDLE_LEVEL) && (rx_s == START_LEVEL)) begin
               state_next = ST_START;
               ferr_next  = 1'b0;
               perr_next  = 1'b0;
            end
         end

         // Re-check the line half a bit in; a return to idle is a glitch
         ST_START: begin
            if (cnt == CNT_MID) begin
               cnt_next   = '0;
               state_next = (rx_s == START_LEVEL) ? ST_DATA : ST_IDLE;
            end else begin
               cnt_next = cnt + CNT_W'(1);
            end
         end

         ST_DATA: begin
            if (cnt == CNT_LAST) begin
               cnt_next   = '0;
               shreg_next = {rx_s, shreg[DATA_BITS-1:1]};
               if (bit_idx == IDX_DATA_LAST) begin
                  bit_idx_next = '0;
                  state_next   = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
               end else begin
                  bit_idx_next = bit_idx + IDX_W'(1);
               end
            end else begin
               cnt_next = cnt + CNT_W'(1);
            end
         end

         // Odd parity wants the overall XOR to be 1, even wants 0
         ST_PARITY: begin
            if (cnt == CNT_LAST) begin
               cnt_next   = '0;
               perr_next  = (PARITY == PARITY_ODD) ? !par_xor : par_xor;
               state_next = ST_STOP;
            end else begin
               cnt_next = cnt + CNT_W'(1);
            end
         end

         ST_STOP: begin
            if (cnt == CNT_LAST) begin
               cnt_next = '0;
               if (rx_s == START_LEVEL) begin
                  ferr_next = 1'b1;
               end
               if (bit_idx == IDX_STOP_LAST) begin
                  bit_idx_next = '0;
                  state_next   = ST_IDLE;
                  frame_done_c = 1'b1;
               end else begin
                  bit_idx_next = bit_idx + IDX_W'(1);
               end
            end else begin
               cnt_next = cnt + CNT_W'(1);
            end
         end

         default: begin
            state_next   = ST_IDLE;
            cnt_next     = '0;
            bit_idx_next = '0;
         end
      endcase
   end

   // Holding register: load on completion if free or being accepted,
   // otherwise drop the new frame and flag overrun
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         uart_DO    <= '0;
         uart_valid <= 1'b0;
         frame_err  <= 1'b0;
         parity_err <= 1'b0;
         overrun    <= 1'b0;
      end else if (frame_done_c && (!uart_valid || uart_ready)) begin
         uart_DO    <= shreg;
         uart_valid <= 1'b1;
         frame_err  <= ferr_next;
         parity_err <= perr_q;
         overrun    <= 1'b0;
      end else if (frame_done_c) begin
         overrun <= 1'b1;
      end else if (uart_valid && uart_ready) begin
         uart_valid <= 1'b0;
         overrun    <= 1'b0;
      end
   end

endmodule
